// File: rtl/palette_pkg.sv
// Shared types, default parameters and helpers for the palette lookup block.
package palette_pkg;

  localparam int DEF_IDX_W = 4;
  localparam int DEF_CH_W  = 4;
  localparam int DEF_BANKS = 2;

  typedef struct packed {
    logic [DEF_CH_W-1:0] r;
    logic [DEF_CH_W-1:0] g;
    logic [DEF_CH_W-1:0] b;
  } rgb_t;

  typedef enum logic {PAL_INIT, PAL_RUN} pal_state_e;

  // Out-of-range bank requests fall back to bank 0.
  function automatic int unsigned clamp_bank(input int unsigned req, input int unsigned banks);
    return (req >= banks) ? 0 : req;
  endfunction

endpackage

// File: rtl/palette_lut_if.sv
// Lookup, bank-select and write-port signals of palette_lut.
// fade_i exists only when PALETTE_FADE_EN is defined.
interface palette_lut_if #(
    parameter int IDX_W = 4,
    parameter int CH_W  = 4,
    parameter int BANKS = 2
);
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic              pix_valid_i;
    logic [IDX_W-1:0]  pix_index_i;
`ifdef PALETTE_FADE_EN
    logic [CH_W:0]     fade_i;
`endif
    logic [CH_W-1:0]   red_o;
    logic [CH_W-1:0]   green_o;
    logic [CH_W-1:0]   blue_o;
    logic              pix_valid_o;
    logic              frame_start_i;
    logic [BANK_W-1:0] bank_req_i;
    logic [BANK_W-1:0] active_bank_o;
    logic              wr_valid_i;
    logic              wr_ready_o;
    logic [BANK_W-1:0] wr_bank_i;
    logic [IDX_W-1:0]  wr_index_i;
    logic [3*CH_W-1:0] wr_rgb_i;
    logic              init_done_o;

    modport master (
        output pix_valid_i, pix_index_i,
`ifdef PALETTE_FADE_EN
        output fade_i,
`endif
        output frame_start_i, bank_req_i, wr_valid_i, wr_bank_i, wr_index_i, wr_rgb_i,
        input  red_o, green_o, blue_o, pix_valid_o, active_bank_o, wr_ready_o, init_done_o
    );

    modport slave (
        input  pix_valid_i, pix_index_i,
`ifdef PALETTE_FADE_EN
        input  fade_i,
`endif
        input  frame_start_i, bank_req_i, wr_valid_i, wr_bank_i, wr_index_i, wr_rgb_i,
        output red_o, green_o, blue_o, pix_valid_o, active_bank_o, wr_ready_o, init_done_o
    );

endinterface

// File: rtl/palette_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module palette_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM primitives; the owner clears it by sweeping.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/palette_lut.sv
// Multi-bank colour palette with frame-synchronous bank switching and a clear-on-reset sweep.
// Define PALETTE_FADE_EN to add a brightness stage (fade_i, latency 3).
module palette_lut
    import palette_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int CH_W  = DEF_CH_W,
    parameter int BANKS = DEF_BANKS
) (
    input logic          clk,
    input logic          reset,
    palette_lut_if.slave bus
);

    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int ADDR_W = BANK_W + IDX_W;
    localparam int DEPTH  = BANKS * (2 ** IDX_W);
    localparam int RGB_W  = 3 * CH_W;

    pal_state_e        state, state_nxt;
    logic [ADDR_W-1:0] sweep_cnt;
    logic              init_done, wr_ready;
    logic [BANK_W-1:0] pending_bank, active_bank;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [RGB_W-1:0]  ram_wdata, ram_rdata;

    logic              s1_valid, s1_blank;
    logic              s2_valid;
    logic [RGB_W-1:0]  s2_rgb;
    logic              out_valid;
    logic [RGB_W-1:0]  out_rgb;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= PAL_INIT;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        init_done = 1'b0;
        wr_ready  = 1'b0;
        case (state)
            PAL_INIT: if (sweep_cnt == ADDR_W'(DEPTH - 1)) state_nxt = PAL_RUN;
            PAL_RUN: begin
                init_done = 1'b1;
                wr_ready  = 1'b1;
            end
            default: state_nxt = PAL_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)                  sweep_cnt <= '0;
        else if (state == PAL_INIT) sweep_cnt <= sweep_cnt + 1'b1;
    end

    // The sweep owns the write port until the palette is cleared; writes to missing banks are dropped.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = sweep_cnt;
        ram_wdata = '0;
        if (state == PAL_INIT) begin
            ram_we = 1'b1;
        end else begin
            ram_we    = bus.wr_valid_i && wr_ready && (32'(bus.wr_bank_i) < BANKS);
            ram_waddr = {bus.wr_bank_i, bus.wr_index_i};
            ram_wdata = bus.wr_rgb_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_bank <= '0;
            active_bank  <= '0;
        end else begin
            pending_bank <= BANK_W'(clamp_bank(32'(bus.bank_req_i), BANKS));
            if (bus.frame_start_i) active_bank <= pending_bank;
        end
    end

    // Stage 1 is the RAM address register: index and active bank are captured with the read,
    // which also makes a same-cycle write invisible to that lookup.
    palette_ram #(.ADDR_W(ADDR_W), .DATA_W(RGB_W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr ({active_bank, bus.pix_index_i}),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_blank <= 1'b1;
            s2_valid <= 1'b0;
            s2_rgb   <= '0;
        end else begin
            s1_valid <= bus.pix_valid_i;
            s1_blank <= (state == PAL_INIT);
            s2_valid <= s1_valid;
            if (s1_valid) s2_rgb <= s1_blank ? '0 : ram_rdata;
        end
    end

`ifdef PALETTE_FADE_EN
    logic [CH_W:0] s1_fade, s2_fade;

    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] ch, input logic [CH_W:0] f);
        logic [2*CH_W:0] p;
        p = (2*CH_W+1)'(ch) * (2*CH_W+1)'(f);
        return p[2*CH_W-1:CH_W];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_fade   <= '0;
            s2_fade   <= '0;
            out_valid <= 1'b0;
            out_rgb   <= '0;
        end else begin
            s1_fade   <= bus.fade_i;
            s2_fade   <= s1_fade;
            out_valid <= s2_valid;
            if (s2_valid)
                out_rgb <= {scale(s2_rgb[3*CH_W-1 -: CH_W], s2_fade),
                            scale(s2_rgb[2*CH_W-1 -: CH_W], s2_fade),
                            scale(s2_rgb[CH_W-1:0],         s2_fade)};
        end
    end
`else
    assign out_valid = s2_valid;
    assign out_rgb   = s2_rgb;
`endif

    assign bus.pix_valid_o   = out_valid;
    assign bus.red_o         = out_rgb[3*CH_W-1 -: CH_W];
    assign bus.green_o       = out_rgb[2*CH_W-1 -: CH_W];
    assign bus.blue_o        = out_rgb[CH_W-1:0];
    assign bus.active_bank_o = active_bank;
    assign bus.wr_ready_o    = wr_ready;
    assign bus.init_done_o   = init_done;

endmodule

// File: tb/tb_palette_lut.sv
// Scoreboard bench for palette_lut against a table-based palette model.
module tb_palette_lut;
  import palette_pkg::*;

  localparam int IDX_W    = DEF_IDX_W;
  localparam int CH_W     = DEF_CH_W;
  localparam int BANKS    = DEF_BANKS;
  localparam int ENTRIES  = 1 << IDX_W;
  localparam int INIT_CYC = BANKS * ENTRIES;
`ifdef PALETTE_FADE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  palette_lut_if #(.IDX_W(IDX_W), .CH_W(CH_W), .BANKS(BANKS)) bus ();
  palette_lut #(.IDX_W(IDX_W), .CH_W(CH_W), .BANKS(BANKS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    rgb_t rgb;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  rgb_t mem_m[BANKS][ENTRIES];
  rgb_t last_m;
  int   act_m, pend_m, cyc;
  int   n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic rgb_t fade_rgb(input rgb_t v, input int f);
    rgb_t o;
    o.r = CH_W'((int'(v.r) * f) / (1 << CH_W));
    o.g = CH_W'((int'(v.g) * f) / (1 << CH_W));
    o.b = CH_W'((int'(v.b) * f) / (1 << CH_W));
    return o;
  endfunction

  function automatic int dut_rgb();
    return int'({bus.red_o, bus.green_o, bus.blue_o});
  endfunction

  task automatic idle();
    bus.pix_valid_i   = 1'b0;
    bus.pix_index_i   = '0;
    bus.frame_start_i = 1'b0;
    bus.wr_valid_i    = 1'b0;
    bus.wr_bank_i     = '0;
    bus.wr_index_i    = '0;
    bus.wr_rgb_i      = '0;
`ifdef PALETTE_FADE_EN
    bus.fade_i        = 5'd16;
`endif
  endtask

  task automatic randomize_inputs();
    bus.pix_valid_i   = 1'($urandom_range(0, 1));
    bus.pix_index_i   = IDX_W'($urandom);
    bus.frame_start_i = ($urandom_range(0, 15) == 0);
    bus.bank_req_i    = 1'($urandom);
    bus.wr_valid_i    = 1'($urandom_range(0, 1));
    bus.wr_bank_i     = 1'($urandom);
    bus.wr_index_i    = IDX_W'($urandom);
    bus.wr_rgb_i      = 12'($urandom);
`ifdef PALETTE_FADE_EN
    bus.fade_i        = 5'($urandom_range(0, 16));
`endif
  endtask

  // Applies the current inputs to the model, advances one clock and checks the status outputs.
  task automatic tick();
    exp_t e;
    if (bus.pix_valid_i) begin
      e.rgb = (cyc < INIT_CYC) ? rgb_t'(0) : mem_m[act_m][bus.pix_index_i];
`ifdef PALETTE_FADE_EN
      e.rgb = fade_rgb(e.rgb, int'(bus.fade_i));
`endif
      e.cyc = cyc;
      sb.push_back(e);
    end
    if (bus.wr_valid_i && cyc >= INIT_CYC && int'(bus.wr_bank_i) < BANKS)
      mem_m[bus.wr_bank_i][bus.wr_index_i] = rgb_t'(bus.wr_rgb_i);
    if (bus.frame_start_i) act_m = pend_m;
    pend_m = (int'(bus.bank_req_i) < BANKS) ? int'(bus.bank_req_i) : 0;
    @(posedge clk);
    #1;
    cyc++;
    check("init_done", int'(bus.init_done_o), int'(cyc >= INIT_CYC));
    check("wr_ready", int'(bus.wr_ready_o), int'(cyc >= INIT_CYC));
    check("active_bank", int'(bus.active_bank_o), act_m);
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
    end
    sb.delete();
    check("flush_valid", int'(bus.pix_valid_o), 0);
    check("reset_rgb", dut_rgb(), 0);
    check("reset_bank", int'(bus.active_bank_o), 0);
    check("reset_done", int'(bus.init_done_o), 0);
    for (int b = 0; b < BANKS; b++)
      for (int i = 0; i < ENTRIES; i++) mem_m[b][i] = '0;
    act_m  = 0;
    pend_m = 0;
    last_m = '0;
    cyc    = 0;
    reset  = 1'b0;
  endtask

  // Monitor: pops an expectation whenever the DUT presents a colour, otherwise checks hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.pix_valid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("latency", cyc, e.cyc + LAT);
          check("rgb", dut_rgb(), int'(e.rgb));
          last_m = e.rgb;
        end
      end else if (!reset) begin
        check("hold_rgb", dut_rgb(), int'(last_m));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    bus.bank_req_i = '0;
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1);

    // Sweep phase: random traffic, writes must be ignored and colours forced to black.
    for (int i = 0; i < INIT_CYC + 4; i++) begin
      randomize_inputs();
      bus.frame_start_i = 1'b0;
      bus.bank_req_i    = '0;
      tick();
    end

    // Write then look up on the next cycle.
    idle();
    bus.wr_valid_i = 1'b1; bus.wr_bank_i = 1'b0; bus.wr_index_i = 4'd3; bus.wr_rgb_i = 12'hCA9;
    tick();
    idle();
    bus.pix_valid_i = 1'b1; bus.pix_index_i = 4'd3;
    tick();

    // Same-cycle write and lookup returns the old value; next-cycle lookup sees the new one.
    idle();
    bus.wr_valid_i = 1'b1; bus.wr_index_i = 4'd5; bus.wr_rgb_i = 12'hFFF;
    bus.pix_valid_i = 1'b1; bus.pix_index_i = 4'd5;
    tick();
    idle();
    bus.pix_valid_i = 1'b1; bus.pix_index_i = 4'd5;
    tick();

    // Bank switch only at frame start; a request changed with the pulse waits a frame.
    idle();
    bus.wr_valid_i = 1'b1; bus.wr_bank_i = 1'b1; bus.wr_index_i = 4'd2; bus.wr_rgb_i = 12'h455;
    tick();
    idle();
    bus.bank_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.pix_valid_i = 1'b1; bus.pix_index_i = 4'd2;
      tick();
    end
    bus.frame_start_i = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.pix_valid_i = 1'b1; bus.pix_index_i = 4'd2;
      tick();
    end
    bus.bank_req_i = 1'b0; bus.frame_start_i = 1'b1;
    tick();
    idle();
    bus.pix_valid_i = 1'b1; bus.pix_index_i = 4'd2;
    tick();
    bus.frame_start_i = 1'b1;
    tick();
    idle();
    bus.pix_valid_i = 1'b1; bus.pix_index_i = 4'd3;
    tick();

`ifdef PALETTE_FADE_EN
    idle();
    bus.pix_valid_i = 1'b1; bus.pix_index_i = 4'd3; bus.fade_i = 5'd8;
    tick();
    bus.fade_i = 5'd16;
    tick();
    bus.fade_i = 5'd0;
    tick();
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      tick();
    end

    // Reset with lookups in flight, then reset again mid-sweep.
    randomize_inputs();
    bus.pix_valid_i = 1'b1;
    tick();
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      randomize_inputs();
      bus.wr_valid_i = 1'b1;
      tick();
    end
    do_reset(1);
    for (int i = 0; i < INIT_CYC + 8; i++) begin
      randomize_inputs();
      bus.frame_start_i = 1'b0;
      tick();
    end
    idle();
    bus.pix_valid_i = 1'b1; bus.pix_index_i = 4'd3;
    tick();
    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      tick();
    end

    idle();
    for (int i = 0; i < LAT + 2; i++) tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
